// File: rtl/chatbot_soc_nios2_gen2_0_cpu_ocimem_sequencer.sv
// OCI debug RAM sequencer: arbitrates synchronised JTAG debug actions and the CPU Avalon slave onto one RAM port.
// Optional feature macro: OCIMEM_JTAG_AUTOINC_EN (JTAG address advances after every completed JTAG op).
module chatbot_soc_nios2_gen2_0_cpu_ocimem_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        JRD     = 3'd1,
        JRD_CAP = 3'd2,
        ARD     = 3'd3,
        ARD_CAP = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Pending JTAG slot; the op always targets the JTAG address current at execution time
    logic              slot_vld;
    logic              slot_is_write;
    logic [31:0]       slot_data;
    logic [ADDR_W-1:0] jtag_addr;
    logic [ADDR_W-1:0] jtag_addr_next;
    logic              last_grant_avs;

    logic              avs_req;
    logic              grant_jtag;
    logic              grant_avs;
    logic              jtag_wr_done;
    logic              jtag_rd_done;
    logic              jtag_done;
    logic              avs_done;
    logic              q_rd;
    logic              q_wr;
    logic              queue_req;
    logic              slot_free;
    logic              queue_ok;
    logic              queue_drop;
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_unused;

    assign jdo_addr   = jdo[26 +: ADDR_W];
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    assign avs_req      = avs_read | avs_write;
    assign grant_jtag   = (state == IDLE) && slot_vld && (!avs_req || last_grant_avs);
    assign grant_avs    = (state == IDLE) && avs_req && !grant_jtag;
    assign jtag_wr_done = grant_jtag && slot_is_write;
    assign jtag_rd_done = (state == JRD_CAP);
    assign jtag_done    = jtag_wr_done || jtag_rd_done;
    assign avs_done     = (grant_avs && !avs_read) || (state == ARD_CAP);

    // A slot that empties this cycle can take a new op without flagging an error
    assign q_wr       = take_action_ocimem_b;
    assign q_rd       = (take_action_ocimem_a & jdo[25]) | take_no_action_ocimem_a;
    assign queue_req  = q_wr | q_rd;
    assign slot_free  = !slot_vld || jtag_done;
    assign queue_ok   = queue_req && slot_free;
    assign queue_drop = queue_req && !slot_free;

`ifdef OCIMEM_JTAG_AUTOINC_EN
    assign jtag_addr_next = jtag_addr + ADDR_W'(1);
`else
    assign jtag_addr_next = jtag_addr;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_jtag && !slot_is_write) begin
                    state_next = JRD;
                end else if (grant_avs && avs_read) begin
                    state_next = ARD;
                end
            end
            JRD:     state_next = JRD_CAP;
            JRD_CAP: state_next = IDLE;
            ARD:     state_next = ARD_CAP;
            ARD_CAP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_we       = 1'b0;
        ram_addr     = jtag_addr;
        ram_wdata    = slot_data;
        avs_readdata = '0;
        case (state)
            IDLE: begin
                if (grant_avs) begin
                    ram_addr  = avs_address;
                    ram_wdata = avs_writedata;
                    ram_we    = avs_write && !avs_read;
                end else if (grant_jtag) begin
                    ram_we = slot_is_write;
                end
            end
            ARD: begin
                ram_addr = avs_address;
            end
            ARD_CAP: begin
                ram_addr     = avs_address;
                avs_readdata = ram_rdata;
            end
            default: begin
                ram_addr = jtag_addr;
            end
        endcase
    end

    assign avs_waitrequest = avs_req && !avs_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld       <= 1'b0;
            slot_is_write  <= 1'b0;
            jtag_addr      <= '0;
            last_grant_avs <= 1'b1;
            MonDReg        <= '0;
            monitor_ready  <= 1'b0;
            monitor_error  <= 1'b0;
        end else begin
            if (queue_ok) begin
                slot_vld      <= 1'b1;
                slot_is_write <= q_wr;
            end else if (jtag_done) begin
                slot_vld <= 1'b0;
            end

            if (grant_jtag) begin
                last_grant_avs <= 1'b0;
            end else if (grant_avs) begin
                last_grant_avs <= 1'b1;
            end

            // An explicit address load overrides any increment from a completing op
            if (take_action_ocimem_a) begin
                jtag_addr <= jdo_addr;
            end else if (jtag_done) begin
                jtag_addr <= jtag_addr_next;
            end

            if (jtag_rd_done) begin
                MonDReg <= ram_rdata;
            end

            if (take_action_ocimem_a || queue_ok) begin
                monitor_ready <= 1'b0;
            end else if (jtag_done) begin
                monitor_ready <= 1'b1;
            end

            if (queue_drop) begin
                monitor_error <= 1'b1;
            end else if (take_action_ocimem_a) begin
                monitor_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (queue_ok && q_wr) begin
            slot_data <= jdo[34:3];
        end
    end

endmodule

// File: tb/tb_chatbot_soc_nios2_gen2_0_cpu_ocimem_sequencer.sv
// Self-checking bench for the OCI RAM sequencer: directed scenarios plus randomized JTAG/Avalon traffic.
module tb_chatbot_soc_nios2_gen2_0_cpu_ocimem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ram [256];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_mon;
    logic [31:0] v20;

    chatbot_soc_nios2_gen2_0_cpu_ocimem_sequencer #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_we                  (ram_we),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic idle_inputs();
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd);
        jdo = '0;
        jdo[33:26] = addr;
        jdo[25] = rd;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = {3'b000, data, 3'b000};
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_n();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (monitor_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic avs_xfer(input bit rd, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] q, output bit ok);
        avs_address = a;
        avs_writedata = d;
        avs_read = rd;
        avs_write = !rd;
        ok = 1'b0;
        q = '0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (avs_waitrequest === 1'b0) begin
                q = avs_readdata;
                ok = 1'b1;
            end
            @(negedge clk);
            if (ok) break;
        end
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", monitor_ready); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        n_cmp++; if (ram_addr !== 8'h0) begin n_err++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        n_cmp++; if (avs_waitrequest !== 1'b0) begin n_err++; $display("FAIL reset_waitreq got=%b exp=0", avs_waitrequest); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_jtag_write_read();
        bit ok;
        pulse_a(8'h10, 1'b0);
        pulse_b(32'hDEADBEEF);
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL jwr_ready_timeout got=0 exp=1"); end
        pulse_a(8'h10, 1'b0);
        pulse_n();
        wait_ready(ok);
        exp_mon = 32'hDEADBEEF;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL jrd_ready_timeout got=0 exp=1"); end
        n_cmp++; if (MonDReg !== exp_mon) begin n_err++; $display("FAIL jrd_mondreg got=%h exp=%h", MonDReg, exp_mon); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL jrd_error got=%b exp=0", monitor_error); end
        n_cmp++; if (ram[8'h10] !== 32'hDEADBEEF) begin n_err++; $display("FAIL jwr_ram got=%h exp=deadbeef", ram[8'h10]); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [31:0] q;
        logic exp_wait;
        do_reset();
        v20 = $urandom;
        avs_xfer(1'b0, 8'h20, v20, q, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL sim_preload_timeout got=0 exp=1"); end
        jdo = '0;
        jdo[33:26] = 8'h20;
        jdo[25] = 1'b1;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
        avs_read = 1'b1;
        avs_address = 8'h20;
        for (int c = 1; c <= 6; c++) begin
            #1;
            exp_wait = (c < 6);
            n_cmp++; if (avs_waitrequest !== exp_wait) begin n_err++; $display("FAIL sim_waitreq_c%0d got=%b exp=%b", c, avs_waitrequest, exp_wait); end
            if (c == 6) begin
                n_cmp++; if (avs_readdata !== v20) begin n_err++; $display("FAIL sim_readdata got=%h exp=%h", avs_readdata, v20); end
            end
            @(negedge clk);
        end
        avs_read = 1'b0;
        exp_mon = v20;
        n_cmp++; if (MonDReg !== exp_mon) begin n_err++; $display("FAIL sim_mondreg got=%h exp=%h", MonDReg, exp_mon); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready got=%b exp=1", monitor_ready); end
    endtask

    task automatic test_contention();
        logic [31:0] d1, d2, a0, a1;
        int k;
        int got;
        int exp_order [4] = '{1, 0, 1, 0};
        d1 = $urandom; d2 = $urandom; a0 = $urandom; a1 = $urandom;
        pulse_a(8'h40, 1'b0);
        jdo = {3'b000, d1, 3'b000};
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        k = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) jdo = {3'b000, d2, 3'b000};
            else take_action_ocimem_b = 1'b0;
            avs_write = 1'b1;
            avs_address = 8'h80 + 8'(k);
            avs_writedata = (k == 0) ? a0 : a1;
            #1;
            got = (ram_we && avs_waitrequest) ? 1 : (!avs_waitrequest ? 0 : 2);
            n_cmp++; if (got != exp_order[c]) begin n_err++; $display("FAIL cont_grant_c%0d got=%0d exp=%0d", c, got, exp_order[c]); end
            if (!avs_waitrequest) k++;
            @(negedge clk);
        end
        avs_write = 1'b0;
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL cont_error got=%b exp=0", monitor_error); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL cont_ready got=%b exp=1", monitor_ready); end
        n_cmp++; if (ram[8'h80] !== a0) begin n_err++; $display("FAIL cont_avs0 got=%h exp=%h", ram[8'h80], a0); end
        n_cmp++; if (ram[8'h81] !== a1) begin n_err++; $display("FAIL cont_avs1 got=%h exp=%h", ram[8'h81], a1); end
`ifdef OCIMEM_JTAG_AUTOINC_EN
        n_cmp++; if (ram[8'h40] !== d1) begin n_err++; $display("FAIL cont_j0 got=%h exp=%h", ram[8'h40], d1); end
        n_cmp++; if (ram[8'h41] !== d2) begin n_err++; $display("FAIL cont_j1 got=%h exp=%h", ram[8'h41], d2); end
`else
        n_cmp++; if (ram[8'h40] !== d2) begin n_err++; $display("FAIL cont_j got=%h exp=%h", ram[8'h40], d2); end
`endif
    endtask

    task automatic test_overflow();
        bit ok;
        logic [31:0] w;
        logic [7:0] ja;
`ifdef OCIMEM_JTAG_AUTOINC_EN
        ja = 8'h42;
`else
        ja = 8'h40;
`endif
        w = $urandom;
        avs_read = 1'b1;
        avs_address = 8'h20;
        @(negedge clk);
        jdo = {3'b000, w, 3'b000};
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        avs_read = 1'b0;
        n_cmp++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL ovf_error_set got=%b exp=1", monitor_error); end
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_ready_timeout got=0 exp=1"); end
        repeat (4) @(negedge clk);
        n_cmp++; if (MonDReg !== exp_mon) begin n_err++; $display("FAIL ovf_read_dropped got=%h exp=%h", MonDReg, exp_mon); end
        n_cmp++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL ovf_ready_idle got=%b exp=1", monitor_ready); end
        n_cmp++; if (ram[ja] !== w) begin n_err++; $display("FAIL ovf_write got=%h exp=%h", ram[ja], w); end
        pulse_a(8'h50, 1'b0);
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL ovf_error_clear got=%b exp=0", monitor_error); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] q;
        avs_xfer(1'b0, 8'h00, 32'h5A5A0000, q, ok);
        pulse_a(8'hFF, 1'b0);
        pulse_b(32'd1);
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_ready1 got=0 exp=1"); end
        pulse_b(32'd2);
        wait_ready(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_ready2 got=0 exp=1"); end
`ifdef OCIMEM_JTAG_AUTOINC_EN
        n_cmp++; if (ram[8'hFF] !== 32'd1) begin n_err++; $display("FAIL wrap_ff got=%h exp=1", ram[8'hFF]); end
        n_cmp++; if (ram[8'h00] !== 32'd2) begin n_err++; $display("FAIL wrap_00 got=%h exp=2", ram[8'h00]); end
`else
        n_cmp++; if (ram[8'hFF] !== 32'd2) begin n_err++; $display("FAIL wrap_ff got=%h exp=2", ram[8'hFF]); end
        n_cmp++; if (ram[8'h00] !== 32'h5A5A0000) begin n_err++; $display("FAIL wrap_00 got=%h exp=5a5a0000", ram[8'h00]); end
`endif
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        logic [31:0] q;
        avs_read = 1'b1;
        avs_address = 8'h20;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        avs_read = 1'b0;
        #1;
        n_cmp++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL rst_mid_mondreg got=%h exp=0", MonDReg); end
        n_cmp++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=0", monitor_ready); end
        n_cmp++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL rst_mid_error got=%b exp=0", monitor_error); end
        n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rst_mid_ram_we got=%b exp=0", ram_we); end
        n_cmp++; if (ram_addr !== 8'h0) begin n_err++; $display("FAIL rst_mid_ram_addr got=%h exp=0", ram_addr); end
        n_cmp++; if (avs_waitrequest !== 1'b0) begin n_err++; $display("FAIL rst_mid_waitreq got=%b exp=0", avs_waitrequest); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_mon = 32'h0;
        avs_xfer(1'b1, 8'h20, 32'h0, q, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_mid_reread_timeout got=0 exp=1"); end
        n_cmp++; if (q !== v20) begin n_err++; $display("FAIL rst_mid_reread got=%h exp=%h", q, v20); end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] q, d;
        logic [7:0] a;
        int kind;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            avs_xfer(1'b0, 8'(i), ref_mem[i], q, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_init_%0d timeout got=0 exp=1", i); end
        end
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            a = 8'($urandom_range(0, 15));
            d = $urandom;
            case (kind)
                0: begin
                    avs_xfer(1'b0, a, d, q, ok);
                    ref_mem[a[3:0]] = d;
                    n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_avs_wr_%0d timeout got=0 exp=1", n); end
                end
                1: begin
                    avs_xfer(1'b1, a, 32'h0, q, ok);
                    n_cmp++; if (!ok || q !== ref_mem[a[3:0]]) begin n_err++; $display("FAIL rnd_avs_rd_%0d a=%h got=%h ok=%b exp=%h", n, a, q, ok, ref_mem[a[3:0]]); end
                end
                2: begin
                    pulse_a(a, 1'b0);
                    pulse_b(d);
                    wait_ready(ok);
                    ref_mem[a[3:0]] = d;
                    n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd_j_wr_%0d timeout got=0 exp=1", n); end
                end
                default: begin
                    pulse_a(a, 1'b1);
                    wait_ready(ok);
                    exp_mon = ref_mem[a[3:0]];
                    n_cmp++; if (!ok || MonDReg !== exp_mon) begin n_err++; $display("FAIL rnd_j_rd_%0d a=%h got=%h ok=%b exp=%h", n, a, MonDReg, ok, exp_mon); end
                end
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (ram[i] !== ref_mem[i]) begin n_err++; $display("FAIL rnd_final_%0d got=%h exp=%h", i, ram[i], ref_mem[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_mon = 32'h0;
        v20 = 32'h0;
        test_reset();
        test_jtag_write_read();
        test_simultaneous();
        test_contention();
        test_overflow();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
